// File: rtl/lsu_pipe.sv
// lsu_pipe -- load/store unit front end for an RV32 core.
//
// Requests are decoded combinationally and issued straight onto a split
// read/write data-memory bus. Loads record {funct3, addr[1:0]} in an
// OUTST-deep in-order queue. When the matching response arrives, the data is
// aligned and extended, then registered into load_data with a one-cycle
// load_valid pulse. Stores are fire-and-forget: they get lane strobes and
// replicated write data.
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned LH/LHU/SH/LW/SW are accepted without a bus request
//               and raise a one-cycle misalign pulse on the next cycle.
//   undefined : every access is issued as-is and misalign stays 0.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   req_valid / req_ready      request handshake
//   req_is_store, req_funct3   access kind (RV32 funct3 encoding)
//   req_addr, req_wdata        byte address, store data
//   dmem_rvalid/rready/raddr   load request channel (word aligned)
//   dmem_rdata/_valid/_ready   load response channel
//   dmem_wvalid/wready/waddr/wdata/wstrb  store channel
//   load_data, load_valid      aligned/extended load result (latency 1)
//   misalign                   misaligned-access pulse (trap build only)
//   outstanding                number of loads awaiting a response
module lsu_pipe #(
  parameter int ADDR_W = 32,
  parameter int OUTST  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_is_store,
  input  logic [2:0]                 req_funct3,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [31:0]                req_wdata,
  output logic                       dmem_rvalid,
  input  logic                       dmem_rready,
  output logic [ADDR_W-1:0]          dmem_raddr,
  input  logic [31:0]                dmem_rdata,
  input  logic                       dmem_rdata_valid,
  output logic                       dmem_rdata_ready,
  output logic                       dmem_wvalid,
  input  logic                       dmem_wready,
  output logic [ADDR_W-1:0]          dmem_waddr,
  output logic [31:0]                dmem_wdata,
  output logic [3:0]                 dmem_wstrb,
  output logic [31:0]                load_data,
  output logic                       load_valid,
  output logic                       misalign,
  output logic [$clog2(OUTST):0]     outstanding
);

  localparam int PTR_W = $clog2(OUTST);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUTST);

  // Store byte-lane strobes; unsupported funct3 yields no lanes.
  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  return 4'b0001 << off;
      3'b001:  return 4'b0011 << off;
      3'b010:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate narrow store data so every lane the strobe may select carries it.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000:  return {4{wd[7:0]}};
      3'b001:  return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Align the addressed bytes to bit 0 and extend to 32 bits.
  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
    logic        [31:0] shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] wide_s;
    shifted = rd >> {off, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = shifted[15:0];
    case (f3)
      3'b000:  begin wide_s = byte_s; return wide_s; end
      3'b001:  begin wide_s = half_s; return wide_s; end
      3'b010:  return shifted;
      3'b100:  return {24'h0, shifted[7:0]};
      3'b101:  return {16'h0, shifted[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  // ---- Stage p0: request decode and bus issue (combinational) ----
  logic             mis_p0;
  logic             full_p0;
  logic [3:0]       strb_p0;
  logic             push_p0;
  logic             pop_p0;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [4:0]       fifo_mem [OUTST];

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    mis_p0 = 1'b0;
    case (req_funct3[1:0])
      2'b01:   mis_p0 = req_addr[0];
      2'b10:   mis_p0 = (req_addr[1:0] != 2'b00);
      default: mis_p0 = 1'b0;
    endcase
  end
`else
  assign mis_p0 = 1'b0;
`endif

  assign full_p0 = (count == FULL_CNT);
  assign strb_p0 = store_strb(req_funct3, req_addr[1:0]);

  always_comb begin
    if (mis_p0)
      req_ready = 1'b1;
    else if (req_is_store)
      req_ready = dmem_wready;
    else
      req_ready = dmem_rready && !full_p0;
  end

  assign dmem_rvalid = req_valid && !req_is_store && !full_p0 && !mis_p0;
  assign dmem_wvalid = req_valid && req_is_store && (strb_p0 != 4'b0000) && !mis_p0;
  assign dmem_raddr  = {req_addr[ADDR_W-1:2], 2'b00};
  assign dmem_waddr  = {req_addr[ADDR_W-1:2], 2'b00};
  assign dmem_wstrb  = strb_p0;
  assign dmem_wdata  = store_data(req_funct3, req_wdata);

  // A full queue blocks the push even if a pop frees a slot this cycle.
  assign push_p0 = dmem_rvalid && dmem_rready;
  assign dmem_rdata_ready = (count != '0);
  assign pop_p0  = dmem_rdata_valid && dmem_rdata_ready;

  // ---- Stage p1: in-order tag queue and registered load result ----
  logic [31:0] load_data_p1;
  logic        load_valid_p1;
  logic [4:0]  head_p0;

  assign head_p0 = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_p0)
      fifo_mem[wr_ptr] <= {req_funct3, req_addr[1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      load_valid_p1 <= 1'b0;
      load_data_p1  <= 32'h0;
    end else begin
      if (push_p0) wr_ptr <= wr_ptr + 1'b1;
      if (pop_p0)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_p0, pop_p0})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      load_valid_p1 <= pop_p0;
      if (pop_p0)
        load_data_p1 <= extend_load(head_p0[4:2], head_p0[1:0], dmem_rdata);
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_p1;
  always_ff @(posedge clk) begin
    if (rst) misalign_p1 <= 1'b0;
    else     misalign_p1 <= req_valid && mis_p0;
  end
  assign misalign = misalign_p1;
`else
  assign misalign = 1'b0;
`endif

  assign load_data   = load_data_p1;
  assign load_valid  = load_valid_p1;
  assign outstanding = count;

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed bench for lsu_pipe (ADDR_W=32, OUTST=4). Load results are
// predicted from a queue of accepted requests and compared in order.
module tb_lsu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        dmem_rvalid, dmem_rready;
  logic [31:0] dmem_raddr;
  logic [31:0] dmem_rdata;
  logic        dmem_rdata_valid, dmem_rdata_ready;
  logic        dmem_wvalid, dmem_wready;
  logic [31:0] dmem_waddr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] load_data;
  logic        load_valid, misalign;
  logic [2:0]  outstanding;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0]  req_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] last_exp;

  always #5 clk = ~clk;

  lsu_pipe #(.ADDR_W(32), .OUTST(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .dmem_rvalid(dmem_rvalid), .dmem_rready(dmem_rready), .dmem_raddr(dmem_raddr),
    .dmem_rdata(dmem_rdata), .dmem_rdata_valid(dmem_rdata_valid),
    .dmem_rdata_ready(dmem_rdata_ready),
    .dmem_wvalid(dmem_wvalid), .dmem_wready(dmem_wready), .dmem_waddr(dmem_waddr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .load_data(load_data), .load_valid(load_valid), .misalign(misalign),
    .outstanding(outstanding)
  );

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [1:0] off,
                                        input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*off +: 8];
    h = (off == 2'd3) ? {8'h00, rd[31:24]} : rd[8*off +: 16];
    case (f3)
      3'd0: return {{24{b[7]}}, b};
      3'd1: return {{16{h[15]}}, h};
      3'd2: return rd >> (8*off);
      3'd4: return {24'h0, b};
      3'd5: return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [2:0] f3, input logic [31:0] a);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = f3; req_addr = a;
    #1;
  endtask

  task automatic drive_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = f3; req_addr = a; req_wdata = wd;
    #1;
  endtask

  // Present one response and predict its result from the oldest request.
  task automatic respond(input logic [31:0] rd);
    logic [4:0] r;
    dmem_rdata = rd; dmem_rdata_valid = 1'b1;
    if (req_q.size() == 0) begin
      chk("resp_without_request", 32'(req_q.size()), 32'd1);
    end else begin
      r = req_q.pop_front();
      exp_q.push_back(model(r[4:2], r[1:0], rd));
    end
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_valid"}, 32'(load_valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_no_expected"}, 32'(exp_q.size()), 32'd1);
    end else begin
      last_exp = exp_q.pop_front();
      chk({tag, "_data"}, load_data, last_exp);
    end
  endtask

  logic [31:0] drain_data [4] = '{32'h8765_F0A1, 32'hC3A5_7E18, 32'h9ABC_DEF0, 32'h0000_80FE};
  logic [2:0]  burst_f3   [5] = '{3'd2, 3'd1, 3'd4, 3'd5, 3'd0};
  logic [31:0] burst_addr [5] = '{32'h100, 32'h102, 32'h201, 32'h302, 32'h400};

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; dmem_rready = 1'b1; dmem_wready = 1'b1;
    dmem_rdata = 32'h0; dmem_rdata_valid = 1'b0;

    // Reset state
    repeat (3) step();
    chk("rst_load_valid", 32'(load_valid), 32'd0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_rdata_ready", 32'(dmem_rdata_ready), 32'd0);
    rst = 1'b0;
    step();

    // Stray response with an empty queue is ignored
    dmem_rdata_valid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_rdata_valid = 1'b0;
    chk("empty_resp_no_valid", 32'(load_valid), 32'd0);
    chk("empty_resp_outst", 32'(outstanding), 32'd0);

    // LB at 0x1003
    drive_load(3'd0, 32'h1003);
    chk("lb_req_ready", 32'(req_ready), 32'd1);
    chk("lb_rvalid", 32'(dmem_rvalid), 32'd1);
    chk("lb_raddr", dmem_raddr, 32'h1000);
    req_q.push_back({3'd0, 2'd3});
    step();
    req_valid = 1'b0;
    chk("lb_outst", 32'(outstanding), 32'd1);
    chk("lb_rdata_ready", 32'(dmem_rdata_ready), 32'd1);
    respond(32'h80FF_0000);
    step();
    dmem_rdata_valid = 1'b0;
    check_result("lb");
    chk("lb_const", load_data, 32'hFFFF_FF80);
    step();
    chk("lb_valid_drop", 32'(load_valid), 32'd0);
    chk("lb_data_hold", load_data, 32'hFFFF_FF80);
    chk("lb_outst_zero", 32'(outstanding), 32'd0);

    // Stores
    drive_store(3'd1, 32'h2002, 32'h1234_ABCD);
    chk("sh_ready", 32'(req_ready), 32'd1);
    chk("sh_wvalid", 32'(dmem_wvalid), 32'd1);
    chk("sh_rvalid", 32'(dmem_rvalid), 32'd0);
    chk("sh_waddr", dmem_waddr, 32'h2000);
    chk("sh_wstrb", 32'(dmem_wstrb), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    drive_store(3'd0, 32'h2001, 32'h1234_ABCD);
    chk("sb_wstrb", 32'(dmem_wstrb), 32'h2);
    chk("sb_wdata", dmem_wdata, 32'hCDCD_CDCD);
    drive_store(3'd2, 32'h2004, 32'h1234_ABCD);
    chk("sw_wstrb", 32'(dmem_wstrb), 32'hF);
    chk("sw_wdata", dmem_wdata, 32'h1234_ABCD);
    drive_store(3'd3, 32'h2004, 32'h1234_ABCD);
    chk("bad_store_wstrb", 32'(dmem_wstrb), 32'h0);
    chk("bad_store_wvalid", 32'(dmem_wvalid), 32'd0);
    dmem_wready = 1'b0;
    drive_store(3'd2, 32'h2004, 32'h1234_ABCD);
    chk("sw_wready_low", 32'(req_ready), 32'd0);
    dmem_wready = 1'b1;
    req_valid = 1'b0;
    step();

    // Five back-to-back loads into a 4-deep queue
    for (int i = 0; i < 5; i++) begin
      drive_load(burst_f3[i], burst_addr[i]);
      chk($sformatf("burst%0d_ready", i), 32'(req_ready), (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) begin
        req_q.push_back({burst_f3[i], burst_addr[i][1:0]});
        step();
      end
    end
    chk("full_outst", 32'(outstanding), 32'd4);
    chk("full_rvalid", 32'(dmem_rvalid), 32'd0);

    // Response while full with a load still waiting: push stays blocked
    respond(32'h1122_3344);
    chk("full_pop_ready", 32'(req_ready), 32'd0);
    step();
    dmem_rdata_valid = 1'b0;
    check_result("full_pop");
    chk("full_pop_outst", 32'(outstanding), 32'd3);
    #1;
    chk("after_pop_ready", 32'(req_ready), 32'd1);
    req_q.push_back({3'd0, 2'd0});
    step();
    req_valid = 1'b0;
    chk("refill_outst", 32'(outstanding), 32'd4);

    // Drain in order, back to back
    for (int i = 0; i < 4; i++) begin
      respond(drain_data[i]);
      step();
      check_result($sformatf("drain%0d", i));
    end
    dmem_rdata_valid = 1'b0;
    step();
    chk("drain_valid_drop", 32'(load_valid), 32'd0);
    chk("drain_outst", 32'(outstanding), 32'd0);

    // Simultaneous push and pop keeps count and order
    drive_load(3'd4, 32'h500);
    req_q.push_back({3'd4, 2'd0});
    step();
    drive_load(3'd1, 32'h602);
    req_q.push_back({3'd1, 2'd2});
    respond(32'h0000_00AB);
    step();
    req_valid = 1'b0;
    chk("pushpop_outst", 32'(outstanding), 32'd1);
    check_result("pushpop_first");
    respond(32'hF00D_0000);
    step();
    dmem_rdata_valid = 1'b0;
    check_result("pushpop_second");
    chk("pushpop_outst_zero", 32'(outstanding), 32'd0);

    // Misaligned LW at 0x3001
    drive_load(3'd2, 32'h3001);
    chk("mis_ready", 32'(req_ready), 32'd1);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_rvalid", 32'(dmem_rvalid), 32'd0);
    step();
    req_valid = 1'b0;
    chk("mis_pulse", 32'(misalign), 32'd1);
    chk("mis_outst", 32'(outstanding), 32'd0);
    step();
    chk("mis_pulse_end", 32'(misalign), 32'd0);
`else
    chk("mis_rvalid", 32'(dmem_rvalid), 32'd1);
    chk("mis_raddr", dmem_raddr, 32'h3000);
    req_q.push_back({3'd2, 2'd1});
    step();
    req_valid = 1'b0;
    chk("mis_no_pulse", 32'(misalign), 32'd0);
    chk("mis_outst", 32'(outstanding), 32'd1);
    respond(32'hAABB_CCDD);
    step();
    dmem_rdata_valid = 1'b0;
    check_result("mis_lw");
    chk("mis_lw_const", load_data, 32'h00AA_BBCC);
`endif

    // Reset with two loads in flight, then stray responses
    drive_load(3'd2, 32'h700);
    step();
    drive_load(3'd2, 32'h704);
    step();
    req_valid = 1'b0;
    chk("mid_outst", 32'(outstanding), 32'd2);
    rst = 1'b1;
    dmem_rdata_valid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    step();
    chk("mid_rst_outst", 32'(outstanding), 32'd0);
    chk("mid_rst_valid", 32'(load_valid), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_valid", 32'(load_valid), 32'd0);
    step();
    chk("post_rst_valid2", 32'(load_valid), 32'd0);
    chk("post_rst_outst", 32'(outstanding), 32'd0);
    chk("post_rst_rdready", 32'(dmem_rdata_ready), 32'd0);
    dmem_rdata_valid = 1'b0;
    step();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
